// File: rtl/gf_mult_arbiter_pkg.sv
// Shared types and constants for the GF(2^163) multiplier arbiter.
package gf_arb_pkg;

    // Operand MSB index of the binary field and the multiplier's start-to-done latency
    localparam int GF_NUM_BITS  = 163;
    localparam int MULT_LATENCY = 165;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Requester index: only two requesters share the multiplier
    typedef logic owner_t;

endpackage

// File: rtl/gf_mult_arbiter_if.sv
// Requester and multiplier signals of the arbiter, bundled for port connection.
// The slave modport is the arbiter's view; master is the environment's view.
interface gf_mult_arbiter_if #(
    parameter int NUM_BITS = 163
);
    logic [1:0]        req;
    logic [NUM_BITS:0] a0;
    logic [NUM_BITS:0] b0;
    logic [NUM_BITS:0] a1;
    logic [NUM_BITS:0] b1;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic [NUM_BITS:0] result;
    logic              err;
    logic              busy;
    logic              mult_start;
    logic [NUM_BITS:0] mult_a;
    logic [NUM_BITS:0] mult_b;
    logic [NUM_BITS:0] mult_product;
    logic              mult_done;

    modport slave (
        input  req, a0, b0, a1, b1, mult_product, mult_done,
        output gnt, rsp_valid, result, err, busy, mult_start, mult_a, mult_b
    );

    modport master (
        output req, a0, b0, a1, b1, mult_product, mult_done,
        input  gnt, rsp_valid, result, err, busy, mult_start, mult_a, mult_b
    );
endinterface

// File: rtl/gf_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr_ptr.
module gf_rr_pick2
    import gf_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     rr_ptr,
    output owner_t     winner,
    output logic       any
);

    // Resolve the winner purely from the current request vector and priority pointer
    always_comb begin
        any    = |req;
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr_ptr;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Shares one GF(2^163) multiplier between two requesters. Picks a winner
// round-robin, latches its operands, starts the multiplier, waits for done
// (or a watchdog abort) and returns the product to the owner. TIMEOUT_CYCLES
// must be at least 170 so that a healthy multiplier always finishes first.
module gf_mult_arbiter
    import gf_arb_pkg::*;
#(
    parameter int NUM_BITS       = GF_NUM_BITS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    gf_mult_arbiter_if.slave bus
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state;
    owner_t            owner;
    owner_t            rr_ptr;
    owner_t            pick_winner;
    logic              pick_any;
    logic [NUM_BITS:0] op_a;
    logic [NUM_BITS:0] op_b;
    logic [NUM_BITS:0] result_q;
    logic              err_q;
    logic              busy_q;
    logic              start_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rsp_q;
    logic [WD_W-1:0]   wd_cnt;

    gf_rr_pick2 u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Arbitration FSM with operand latches, watchdog and registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            gnt_q    <= 2'b00;
            rsp_q    <= 2'b00;
            wd_cnt   <= '0;
        end else begin
            gnt_q   <= 2'b00;
            rsp_q   <= 2'b00;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner   <= pick_winner;
                        op_a    <= pick_winner ? bus.a1 : bus.a0;
                        op_b    <= pick_winner ? bus.b1 : bus.b0;
                        gnt_q   <= 2'b01 << pick_winner;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.mult_done) begin
                        result_q <= bus.mult_product;
                        err_q    <= 1'b0;
                        rsp_q    <= 2'b01 << owner;
                        state    <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        rsp_q    <= 2'b01 << owner;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= ~owner;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_q;
    assign bus.result     = result_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.mult_start = start_q;
    assign bus.mult_a     = op_a;
    assign bus.mult_b     = op_b;

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Self-checking bench for gf_mult_arbiter with a behavioural GF(2^163)
// multiplier standing in for the real core.
module tb_gf_mult_arbiter;
    import gf_arb_pkg::*;

    localparam int NB             = GF_NUM_BITS;
    localparam int W              = NB + 1;
    localparam int TIMEOUT_CYCLES = 255;
    // From the gnt/mult_start cycle to the rsp_valid cycle
    localparam int NORMAL_LAT     = MULT_LATENCY + 1;
    localparam int TIMEOUT_LAT    = TIMEOUT_CYCLES + 1;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   exp_gnt;
        logic [W-1:0] exp_result;
        logic         exp_err;
        bit           scramble;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic stub_enable   = 1'b1;
    logic spurious_done = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic model_rr;

    always #5 clk = ~clk;

    gf_mult_arbiter_if #(.NUM_BITS(NB)) bus ();

    gf_mult_arbiter #(
        .NUM_BITS       (NB),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Field multiply: carry-less product, then reduce by x^163+x^7+x^6+x^3+1
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*NB:0] p;
        logic [2*NB:0] aw;
        logic [2*NB:0] poly;
        p    = '0;
        aw   = '0;
        aw[W-1:0] = a;
        poly = '0;
        poly[NB] = 1'b1;
        poly[7]  = 1'b1;
        poly[6]  = 1'b1;
        poly[3]  = 1'b1;
        poly[0]  = 1'b1;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ (aw << i);
        for (int i = 2 * NB; i >= NB; i--)
            if (p[i]) p = p ^ (poly << (i - NB));
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] randOperand();
        logic [191:0] r;
        logic [W-1:0] v;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
        v = '0;
        v[W-2:0] = r[W-2:0];
        return v;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] req, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                   input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] exp_gnt,
                                   input logic [W-1:0] exp_result, input logic exp_err, input bit scramble);
        vec_t v;
        v.req = req; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.exp_gnt = exp_gnt; v.exp_result = exp_result; v.exp_err = exp_err; v.scramble = scramble;
        return v;
    endfunction

    // Multiplier model: done arrives MULT_LATENCY cycles after the start cycle,
    // and the product is formed from the operands the arbiter holds at that time
    logic         stub_busy;
    logic         stub_done;
    int           stub_cnt;
    logic [W-1:0] stub_prod;
    always @(posedge clk) begin
        if (rst) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_prod <= '0;
        end else begin
            stub_done <= 1'b0;
            if (stub_busy) begin
                if (stub_cnt == MULT_LATENCY - 1) begin
                    stub_busy <= 1'b0;
                    stub_done <= stub_enable;
                    stub_prod <= gf_mul(bus.mult_a, bus.mult_b);
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end else if (bus.mult_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 1;
            end
        end
    end
    assign bus.mult_done    = stub_done | spurious_done;
    assign bus.mult_product = stub_prod;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic [W-1:0] a1, input logic [W-1:0] b1);
        bus.req = req;
        bus.a0  = a0;
        bus.b0  = b0;
        bus.a1  = a1;
        bus.b1  = b1;
    endtask

    // One complete request, started at a negedge with the arbiter idle
    task automatic runTransaction(input vec_t v, input int exp_lat, input string tag);
        int           n;
        logic [W-1:0] cap_a;
        logic [W-1:0] cap_b;
        cap_a = v.exp_gnt[1] ? v.a1 : v.a0;
        cap_b = v.exp_gnt[1] ? v.b1 : v.b0;
        applyStimulus(v.req, v.a0, v.b0, v.a1, v.b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 2'b00 && n < 10);
        checkOutput({tag, " gnt"}, W'(bus.gnt), W'(v.exp_gnt));
        checkOutput({tag, " gnt latency"}, W'(n), W'(1));
        checkOutput({tag, " mult_start"}, W'(bus.mult_start), W'(1));
        checkOutput({tag, " mult_a"}, bus.mult_a, cap_a);
        checkOutput({tag, " mult_b"}, bus.mult_b, cap_b);
        bus.req = 2'b00;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < TIMEOUT_CYCLES + 20) begin
            if (v.scramble) begin
                bus.a0 = randOperand();
                bus.a1 = randOperand();
            end
            @(negedge clk);
            n++;
            if (v.scramble && bus.rsp_valid == 2'b00)
                checkOutput({tag, " mult_a held"}, bus.mult_a, cap_a);
        end
        checkOutput({tag, " rsp_valid"}, W'(bus.rsp_valid), W'(v.exp_gnt));
        checkOutput({tag, " rsp latency"}, W'(n), W'(exp_lat));
        checkOutput({tag, " result"}, bus.result, v.exp_result);
        checkOutput({tag, " err"}, W'(bus.err), W'(v.exp_err));
        model_rr = ~v.exp_gnt[1];
        @(negedge clk);
        checkOutput({tag, " busy after"}, W'(bus.busy), W'(0));
    endtask

    initial begin
        vec_t         tbl [6];
        vec_t         v;
        logic [1:0]   cont_seq [3];
        logic [W-1:0] big;
        int           gi;
        int           ri;
        int           n;
        int           seen;
        logic         own;

        big = '0;
        big[NB-1] = 1'b1;

        // Reset with both requests already raised for the contention sequence
        rst = 1'b1;
        applyStimulus(2'b11, W'(5), W'(7), W'(9), W'(9));
        repeat (3) @(negedge clk);
        checkOutput("reset busy", W'(bus.busy), W'(0));
        checkOutput("reset gnt", W'(bus.gnt), W'(0));
        checkOutput("reset rsp_valid", W'(bus.rsp_valid), W'(0));
        checkOutput("reset mult_start", W'(bus.mult_start), W'(0));
        checkOutput("reset result", bus.result, W'(0));
        checkOutput("reset err", W'(bus.err), W'(0));
        checkOutput("reset mult_a", bus.mult_a, W'(0));
        model_rr = 1'b0;
        rst = 1'b0;

        // Both requests held: grants alternate 0, 1, 0
        cont_seq[0] = 2'b01;
        cont_seq[1] = 2'b10;
        cont_seq[2] = 2'b01;
        gi = 0;
        ri = 0;
        n  = 0;
        while (ri < 3 && n < 3 * (TIMEOUT_CYCLES + 10)) begin
            @(negedge clk);
            n++;
            if (bus.gnt != 2'b00) begin
                if (gi < 3) checkOutput("contention gnt", W'(bus.gnt), W'(cont_seq[gi]));
                gi++;
                if (gi == 3) bus.req = 2'b00;
            end
            if (bus.rsp_valid != 2'b00) begin
                if (ri < 3) begin
                    checkOutput("contention rsp_valid", W'(bus.rsp_valid), W'(cont_seq[ri]));
                    checkOutput("contention result", bus.result, cont_seq[ri][1] ? W'(8'h41) : W'(8'h1B));
                    checkOutput("contention err", W'(bus.err), W'(0));
                end
                ri++;
            end
        end
        checkOutput("contention responses", W'(ri), W'(3));
        model_rr = 1'b1;
        @(negedge clk);

        // Directed vectors; the tie cases exercise priority alternation
        tbl[0] = mkVec(2'b01, W'(2), W'(3), W'(0), W'(0), 2'b01, W'(6), 1'b0, 1'b1);
        tbl[1] = mkVec(2'b10, W'(0), W'(0), big, W'(2), 2'b10, W'(8'hC9), 1'b0, 1'b0);
        tbl[2] = mkVec(2'b01, big, W'(2), W'(0), W'(0), 2'b01, W'(8'hC9), 1'b0, 1'b0);
        tbl[3] = mkVec(2'b11, W'(5), W'(7), W'(9), W'(9), 2'b10, W'(8'h41), 1'b0, 1'b0);
        tbl[4] = mkVec(2'b11, W'(5), W'(7), W'(9), W'(9), 2'b01, W'(8'h1B), 1'b0, 1'b0);
        tbl[5] = mkVec(2'b10, W'(0), W'(0), W'(0), W'(8'hFF), 2'b10, W'(0), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) runTransaction(tbl[i], NORMAL_LAT, $sformatf("vec%0d", i));

        // Multiplier never answers: watchdog abort, then normal service resumes
        stub_enable = 1'b0;
        runTransaction(mkVec(2'b01, W'(3), W'(3), W'(0), W'(0), 2'b01, W'(0), 1'b1, 1'b0), TIMEOUT_LAT, "timeout");
        stub_enable = 1'b1;
        runTransaction(mkVec(2'b01, W'(3), W'(3), W'(0), W'(0), 2'b01, W'(5), 1'b0, 1'b0), NORMAL_LAT, "post-timeout");

        // A done pulse while idle must not produce a response
        spurious_done = 1'b1;
        @(negedge clk);
        spurious_done = 1'b0;
        checkOutput("stray done busy", W'(bus.busy), W'(0));
        checkOutput("stray done rsp", W'(bus.rsp_valid), W'(0));
        @(negedge clk);
        checkOutput("stray done rsp later", W'(bus.rsp_valid), W'(0));

        // Reset in the middle of WAIT abandons the operation silently
        applyStimulus(2'b01, W'(2), W'(5), W'(0), W'(0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 2'b00 && n < 10);
        checkOutput("midreset gnt", W'(bus.gnt), W'(2'b01));
        bus.req = 2'b00;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset busy", W'(bus.busy), W'(0));
        seen = 0;
        repeat (MULT_LATENCY + 20) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen++;
        end
        checkOutput("midreset no rsp", W'(seen), W'(0));
        model_rr = 1'b0;
        runTransaction(mkVec(2'b11, W'(5), W'(7), W'(9), W'(9), 2'b01, W'(8'h1B), 1'b0, 1'b0), NORMAL_LAT, "rr restart");
        runTransaction(mkVec(2'b10, W'(0), W'(0), big, W'(2), 2'b10, W'(8'hC9), 1'b0, 1'b0), NORMAL_LAT, "post-reset req1");

        // Random requests checked against the field model and round-robin rule
        for (int i = 0; i < 12; i++) begin
            v.req = 2'($urandom_range(1, 3));
            v.a0  = randOperand();
            v.b0  = randOperand();
            v.a1  = randOperand();
            v.b1  = randOperand();
            own   = (v.req == 2'b11) ? model_rr : (v.req == 2'b10);
            v.exp_gnt    = own ? 2'b10 : 2'b01;
            v.exp_result = own ? gf_mul(v.a1, v.b1) : gf_mul(v.a0, v.b0);
            v.exp_err    = 1'b0;
            v.scramble   = 1'b0;
            runTransaction(v, NORMAL_LAT, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] stopped");
    end

endmodule
